// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port framebuffer RAM between display scan-out reads,
//   drawing-engine writes and host readback reads. Scan-out always wins and
//   sees a fixed 3-cycle read latency; draw writes and host reads alternate
//   round-robin in the remaining slots.
//
// Ports
//   CLK, RST_BTN                 clock, synchronous active-high reset
//   disp_req/disp_addr           scan-out read request (single-cycle pulse)
//   disp_valid/disp_data         scan-out read response (pulse, data held)
//   wr_valid/wr_addr/wr_data     draw write request, held until wr_ready
//   wr_ready                     draw write accepted this cycle
//   rd_valid/rd_addr             host read request, held until rd_ready
//   rd_ready                     host read accepted this cycle
//   rd_data_valid/rd_data        host read response (pulse, data held)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port (rdata 1 cycle late)
//   stat_clr/stat_wr_stall       saturating write-stall cycle counter
module vram_arbiter #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned STAT_W = 16
) (
    input  logic              CLK,
    input  logic              RST_BTN,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_wr_stall
);

    // Which of write/read is favoured when both are waiting.
    typedef enum logic {PREF_WR, PREF_RD} rr_t;
    // Owner of an in-flight read.
    typedef enum logic {SRC_DISP, SRC_HOST} src_t;

    rr_t  rr;
    logic tag1_v, tag2_v;
    src_t tag1_src, tag2_src;

    logic grant_disp, grant_wr, grant_rd;

    always_comb begin
        grant_disp = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        if (!RST_BTN) begin
            if (disp_req) begin
                grant_disp = 1'b1;
            end else if (wr_valid && (!rd_valid || rr == PREF_WR)) begin
                grant_wr = 1'b1;
            end else if (rd_valid) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            rr            <= PREF_WR;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            tag1_v        <= 1'b0;
            tag1_src      <= SRC_DISP;
            tag2_v        <= 1'b0;
            tag2_src      <= SRC_DISP;
            disp_valid    <= 1'b0;
            disp_data     <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            stat_wr_stall <= '0;
        end else begin
            // Display grants leave the pointer alone so it cannot skew fairness.
            if (grant_wr) begin
                rr <= PREF_RD;
            end else if (grant_rd) begin
                rr <= PREF_WR;
            end

            // Issue stage: one access per cycle, in grant order.
            mem_en    <= grant_disp | grant_wr | grant_rd;
            mem_we    <= grant_wr;
            mem_wdata <= grant_wr ? wr_data : '0;
            if (grant_disp) begin
                mem_addr <= disp_addr;
            end else if (grant_wr) begin
                mem_addr <= wr_addr;
            end else if (grant_rd) begin
                mem_addr <= rd_addr;
            end else begin
                mem_addr <= '0;
            end

            // Tag stage 1 rides alongside the RAM access, stage 2 alongside
            // the returning mem_rdata; the response register follows.
            tag1_v   <= grant_disp | grant_rd;
            tag1_src <= grant_disp ? SRC_DISP : SRC_HOST;
            tag2_v   <= tag1_v;
            tag2_src <= tag1_src;

            disp_valid    <= tag2_v && (tag2_src == SRC_DISP);
            rd_data_valid <= tag2_v && (tag2_src == SRC_HOST);
            if (tag2_v && tag2_src == SRC_DISP) begin
                disp_data <= mem_rdata;
            end
            if (tag2_v && tag2_src == SRC_HOST) begin
                rd_data <= mem_rdata;
            end

            if (stat_clr) begin
                stat_wr_stall <= '0;
            end else if (wr_valid && !grant_wr && stat_wr_stall != '1) begin
                stat_wr_stall <= stat_wr_stall + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Scoreboard bench for vram_arbiter. A driver applies directed and random
//   stimulus and, from a reference model of the arbitration rules and a
//   reference memory image, pushes expected RAM accesses and read responses
//   into queues. A monitor on the falling edge pops and compares them.
module tb_vram_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int SW = 4;

    logic          CLK = 1'b0;
    logic          RST_BTN = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stat_clr = 1'b0;
    logic [SW-1:0] stat_wr_stall;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_clr(stat_clr), .stat_wr_stall(stat_wr_stall)
    );

    always #5 CLK = ~CLK;

    // Framebuffer RAM: synchronous, read data one cycle after the access.
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge CLK) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          en;
        logic          we;
        logic          zero;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    iss_t  iss_q[$];
    resp_t disp_q[$];
    resp_t rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic          favour_wr = 1'b1;
    logic          exp_wr_ready = 1'b0;
    logic          exp_rd_ready = 1'b0;
    int            stat_cur = 0;
    int            stat_next = 0;
    logic          rst_cur = 1'b0;
    logic          rst_prev = 1'b0;
    logic          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic dq, input logic [AW-1:0] da,
                         input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra, input logic clr);
        logic gd, gw, gr;
        iss_t  e;
        resp_t r;
        @(posedge CLK);
        #1;
        RST_BTN = rst; disp_req = dq; disp_addr = da;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; stat_clr = clr;

        rst_prev = rst_cur;
        rst_cur  = rst;
        stat_cur = stat_next;

        gd = !rst && dq;
        gw = !rst && !dq && wv && (!rv || favour_wr);
        gr = !rst && !dq && rv && !gw;
        exp_wr_ready = gw;
        exp_rd_ready = gr;
        if (rst)     favour_wr = 1'b1;
        else if (gw) favour_wr = 1'b0;
        else if (gr) favour_wr = 1'b1;

        e.due   = cyc + 1;
        e.zero  = rst;
        e.en    = gd || gw || gr;
        e.we    = gw;
        e.addr  = gd ? da : (gw ? wa : ra);
        e.wdata = wd;
        iss_q.push_back(e);

        // Reads see every write granted before them.
        if (gw) ref_mem[wa] = wd;
        if (gd) begin r.due = cyc + 3; r.data = ref_mem[da]; disp_q.push_back(r); end
        if (gr) begin r.due = cyc + 3; r.data = ref_mem[ra]; rd_q.push_back(r); end

        if (rst) begin
            while (disp_q.size() > 0 && disp_q[$].due > cyc) void'(disp_q.pop_back());
            while (rd_q.size() > 0 && rd_q[$].due > cyc) void'(rd_q.pop_back());
            stat_next = 0;
        end else if (clr) begin
            stat_next = 0;
        end else if (wv && !gw && stat_cur < (1 << SW) - 1) begin
            stat_next = stat_cur + 1;
        end else begin
            stat_next = stat_cur;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Monitor
    initial begin
        iss_t  e;
        resp_t r;
        logic  exp_v;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                chk("wr_ready", 32'(wr_ready), 32'(exp_wr_ready));
                chk("rd_ready", 32'(rd_ready), 32'(exp_rd_ready));
                chk("stat_wr_stall", 32'(stat_wr_stall), 32'(stat_cur));

                if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
                    e = iss_q.pop_front();
                    chk("mem_en", 32'(mem_en), 32'(e.en));
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    if (e.en) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    if (e.zero) begin
                        chk("mem_addr_rst", 32'(mem_addr), 32'd0);
                        chk("mem_wdata_rst", 32'(mem_wdata), 32'd0);
                    end
                end

                exp_v = (disp_q.size() > 0 && disp_q[0].due == cyc);
                chk("disp_valid", 32'(disp_valid), 32'(exp_v));
                if (exp_v) begin
                    r = disp_q.pop_front();
                    chk("disp_data", 32'(disp_data), 32'(r.data));
                end

                exp_v = (rd_q.size() > 0 && rd_q[0].due == cyc);
                chk("rd_data_valid", 32'(rd_data_valid), 32'(exp_v));
                if (exp_v) begin
                    r = rd_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(r.data));
                end

                if (rst_prev) begin
                    chk("disp_data_rst", 32'(disp_data), 32'd0);
                    chk("rd_data_rst", 32'(rd_data), 32'd0);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic          w_pend, r_pend, last_dq, dq;
        logic [AW-1:0] w_a, r_a;
        logic [DW-1:0] w_d;

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        ram[17'h00123]     = 8'h5A;
        ref_mem[17'h00123] = 8'h5A;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom),
                  DW'($urandom), 1'($urandom), AW'($urandom), 1'($urandom));
            mon_en = (i == 1);
        end
        repeat (7) idle();

        // Display read
        drive(1'b0, 1'b1, 17'h00123, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (4) idle();

        // Collision with display, stall counted once
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b1, 17'h00200, 1'b1, 17'h00010, 8'h33, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 17'h00010, 8'h33, 1'b0, '0, 1'b0);
        repeat (4) idle();

        // Round-robin after reset
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, AW'(17'h00030 + i), DW'(8'hC0 + i),
                  1'b1, AW'(17'h00030 + i), 1'b0);
        end
        repeat (4) idle();

        // Read-after-write
        drive(1'b0, 1'b0, '0, 1'b1, 17'h01000, 8'hA5, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 17'h01000, 1'b0);
        repeat (4) idle();

        // Reset while a display read is in flight
        drive(1'b0, 1'b1, 17'h00123, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (4) idle();

        // Stall counter saturation, then clear
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, AW'(i), 1'b1, 17'h00050, 8'h77, 1'b0, '0, 1'b0);
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        repeat (4) idle();

        // Random traffic with held requests
        w_pend = 1'b0; r_pend = 1'b0; last_dq = 1'b0;
        w_a = '0; r_a = '0; w_d = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!w_pend && $urandom_range(0, 2) == 0) begin
                w_pend = 1'b1; w_a = AW'($urandom_range(0, 15)); w_d = DW'($urandom);
            end
            if (!r_pend && $urandom_range(0, 2) == 0) begin
                r_pend = 1'b1; r_a = AW'($urandom_range(0, 15));
            end
            dq = !last_dq && ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 199) == 0), dq, AW'($urandom_range(0, 15)),
                  w_pend, w_a, w_d, r_pend, r_a, 1'($urandom_range(0, 99) == 0));
            if (exp_wr_ready) w_pend = 1'b0;
            if (exp_rd_ready) r_pend = 1'b0;
            last_dq = dq;
        end

        repeat (6) idle();
        @(negedge CLK);
        #1;
        chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port framebuffer RAM between three requesters: display scan-out reads, drawing-engine writes and host readback reads.
- Scan-out has absolute priority and a fixed read latency, so the VGA timing path never stalls.
- Draw writes and host reads share the leftover slots round-robin.
- Sits between the display timing/pixel pipeline in top and the framebuffer RAM instance.

Parameters:
- ADDR_W, 17, framebuffer address width (320x240 = 76800 words).
- DATA_W, 8, framebuffer word width (palette index).
- STAT_W, 16, width of the write-stall statistics counter.

Ports:
- CLK  in  1  system clock.
- RST_BTN  in  1  reset, synchronous, active-high.
- disp_req  in  1  scan-out read request, single-cycle pulse.
- disp_addr  in  ADDR_W  scan-out read address, sampled with disp_req.
- disp_valid  out  1  scan-out data valid pulse.
- disp_data  out  DATA_W  scan-out read data.
- wr_valid  in  1  draw write request; held until accepted.
- wr_addr  in  ADDR_W  draw write address.
- wr_data  in  DATA_W  draw write data.
- wr_ready  out  1  draw write accepted this cycle.
- rd_valid  in  1  host read request; held until accepted.
- rd_addr  in  ADDR_W  host read address.
- rd_ready  out  1  host read accepted this cycle.
- rd_data_valid  out  1  host read data valid pulse.
- rd_data  out  DATA_W  host read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after the access cycle.
- stat_clr  in  1  clears the stall counter.
- stat_wr_stall  out  STAT_W  saturating count of write-stall cycles.

Behaviour:
- Reset (RST_BTN high at a rising CLK edge):
  - All registered outputs go to 0: mem_*, disp_valid/data, rd_data_valid/data, stat_wr_stall.
  - Round-robin pointer is set to favour write.
  - Response tag pipeline is cleared, so in-flight reads produce no valid pulse after reset.
  - wr_ready and rd_ready are 0 while RST_BTN is high.
- Grant (combinational in request cycle T):
  - If disp_req=1, display wins.
  - Else if only one of wr_valid/rd_valid is high, that requester wins.
  - Else both are high: the requester not granted last wins.
  - wr_ready = grant_wr; rd_ready = grant_rd. A transfer occurs on valid && ready.
- Round-robin pointer updates only on a write or host-read grant; display grants leave it unchanged.
- Issue (cycle T+1): mem_en, mem_we, mem_addr and mem_wdata are registered from the winner.
  - mem_we=1 only for a write.
  - mem_en=0 and mem_we=0 in idle cycles.
- Response:
  - A 2-stage tag pipeline (valid, src) tracks every read.
  - mem_rdata is returned in T+2 and registered into disp_data or rd_data at T+3.
  - The matching valid is a one-cycle pulse at T+3.
  - Fixed read latency is 3 cycles for both read ports.
  - disp_data and rd_data hold their value until overwritten.
  - Write grants produce no response.
- Ordering: accesses reach the RAM strictly in grant order. A read granted after a write to the same address returns the new data.
- Display rate contract:
  - The display never asserts disp_req in two consecutive cycles; pix_stb-derived requests come at most 1 per 4 CLK.
  - This bounds a waiting write/read to at most 3 cycles to acceptance.
  - If the contract is violated, display still wins every cycle; no corruption, only starvation.
- Stall counter:
  - Increments each cycle that wr_valid=1 && wr_ready=0 and RST_BTN=0.
  - Saturates at 2^STAT_W-1.
  - stat_clr=1 forces 0 and has priority over increment.
- Reset mid-operation: an accepted but not yet returned read is dropped. The requester re-issues it after reset.

Test Plan:
1. Reset:
   - Stimulus: drive random inputs, RST_BTN=1 for 2 cycles.
   - Required: all outputs 0 during and one cycle after; wr_ready=rd_ready=0 during reset.
2. Display read:
   - Stimulus: RAM[0x00123]=0x5A; disp_req=1 with addr 0x00123 at cycle 10.
   - Required: mem_en=1, mem_we=0, mem_addr=0x00123 at cycle 11; disp_valid=1 and disp_data=0x5A at cycle 13 only.
3. Collision:
   - Stimulus: wr_valid (addr 0x00010, data 0x33) and disp_req both asserted in cycle T.
   - Required: wr_ready=0 at T and 1 at T+1; mem_we=1 with addr 0x00010 at T+2; stat_wr_stall=1.
4. Round-robin:
   - Stimulus: after reset, hold wr_valid and rd_valid high for 6 cycles with no disp_req.
   - Required: grants W,R,W,R,W,R; rd_data_valid pulses 3 times, each 3 cycles after its rd_ready.
5. Read-after-write:
   - Stimulus: write 0xA5 to 0x01000, then read 0x01000 on the next grant.
   - Required: rd_data=0xA5 with rd_data_valid=1.
6. Reset mid-flight and saturation:
   - Stimulus A: disp_req at T, RST_BTN=1 at T+1.
   - Required A: disp_valid stays 0 at T+3.
   - Stimulus B: with STAT_W=4, stall wr_valid for 20 cycles.
   - Required B: stat_wr_stall=15; one-cycle stat_clr returns it to 0.
